// File: rtl/evm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : evm_pkg
// Brief  : Shared types and constants for the EVM voting front end.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package evm_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LOCKOUT = 1'b1
    } vote_state_t;

    localparam int NUM_CAND                = 4;
    localparam int CAND_CNT_W              = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_LOCKOUT_CYCLES  = 125000000;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

    // Number of candidates whose rising edge landed in the same cycle.
    function automatic logic [CAND_CNT_W-1:0] count_set(input logic [NUM_CAND-1:0] v);
        logic [CAND_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            cnt = cnt + CAND_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vote_recorder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vote_recorder_if
// Brief  : Button/mode inputs and tally/status outputs of the vote recorder.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface vote_recorder_if #(
    parameter int COUNT_W = 4
);
    import evm_pkg::*;

    logic                mode;
    logic [NUM_CAND-1:0] button_raw;
    logic                valid_vote_casted;
    logic                invalid_press;
    logic                busy;
    logic [COUNT_W-1:0]  candidate1_vote;
    logic [COUNT_W-1:0]  candidate2_vote;
    logic [COUNT_W-1:0]  candidate3_vote;
    logic [COUNT_W-1:0]  candidate4_vote;
    logic                candidate1_button_press;
    logic                candidate2_button_press;
    logic                candidate3_button_press;
    logic                candidate4_button_press;

    modport master (
        output mode, button_raw,
        input  valid_vote_casted, invalid_press, busy,
        input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        input  candidate1_button_press, candidate2_button_press,
        input  candidate3_button_press, candidate4_button_press
    );

    modport slave (
        input  mode, button_raw,
        output valid_vote_casted, invalid_press, busy,
        output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        output candidate1_button_press, candidate2_button_press,
        output candidate3_button_press, candidate4_button_press
    );

endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : button_debounce
// Brief  : Two-flop synchroniser plus stable-count debounce for one button.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic button_raw,
    output logic      button_level
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
            // Any cycle of agreement restarts the stability window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign button_level = r_level;

endmodule
`default_nettype wire

// File: rtl/vote_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vote_recorder
// Brief  : Debounced candidate buttons, one-vote-per-session FSM, tallies.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module vote_recorder
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES,
    parameter int COUNT_W         = 4
) (
    input wire logic       clock,
    input wire logic       reset,
    vote_recorder_if.slave bus
);
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0]  C_LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] C_TALLY_MAX = {COUNT_W{1'b1}};

    logic [NUM_CAND-1:0]   w_deb;
    logic [NUM_CAND-1:0]   w_rise;
    logic [CAND_CNT_W-1:0] w_rise_cnt;
    logic [NUM_CAND-1:0]   r_deb_d;

    vote_state_t           r_state;
    logic [LOCK_W-1:0]     r_lock_cnt;
    logic                  r_valid;
    logic                  r_invalid;
    logic                  r_busy;
    logic [COUNT_W-1:0]    r_tally [NUM_CAND];

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_button
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock        (clock),
            .reset        (reset),
            .button_raw   (bus.button_raw[i]),
            .button_level (w_deb[i])
        );
    end

    assign w_rise     = w_deb & ~r_deb_d;
    assign w_rise_cnt = count_set(w_rise);

    // Edge history runs in every state so a button held through lockout
    // never looks like a fresh press once the FSM is back in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= w_deb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_valid    <= 1'b0;
            r_invalid  <= 1'b0;
            r_busy     <= 1'b0;
            r_tally    <= '{default: '0};
        end else begin
            r_valid   <= 1'b0;
            r_invalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_lock_cnt <= '0;
                    if (bus.mode == MODE_VOTE) begin
                        if (w_rise_cnt == CAND_CNT_W'(1)) begin
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= LOCKOUT;
                            for (int i = 0; i < NUM_CAND; i++) begin
                                if (w_rise[i] && (r_tally[i] != C_TALLY_MAX)) begin
                                    r_tally[i] <= r_tally[i] + COUNT_W'(1);
                                end
                            end
                        end else if (w_rise_cnt > CAND_CNT_W'(1)) begin
                            r_invalid <= 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (r_lock_cnt == C_LOCK_LAST) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid_vote_casted       = r_valid;
    assign bus.invalid_press           = r_invalid;
    assign bus.busy                    = r_busy;
    assign bus.candidate1_vote         = r_tally[0];
    assign bus.candidate2_vote         = r_tally[1];
    assign bus.candidate3_vote         = r_tally[2];
    assign bus.candidate4_vote         = r_tally[3];
    assign bus.candidate1_button_press = w_deb[0];
    assign bus.candidate2_button_press = w_deb[1];
    assign bus.candidate3_button_press = w_deb[2];
    assign bus.candidate4_button_press = w_deb[3];

endmodule
`default_nettype wire

// File: tb/tb_vote_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_vote_recorder
// Brief  : Directed vector bench for vote_recorder (short debounce/lockout).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_vote_recorder;

    logic clock;
    logic reset;

    vote_recorder_if #(.COUNT_W(4)) bus ();

    vote_recorder #(
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (10),
        .COUNT_W         (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       mode;
        logic [3:0] press;
        int         exp_valid;
        int         exp_invalid;
        logic [3:0] exp_level;
        logic [15:0] exp_tally;   // {cand4, cand3, cand2, cand1}
    } vec_t;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_inv   = 0;
    int excl_err = 0;
    logic saw_press1 = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.valid_vote_casted) n_valid++;
            if (bus.invalid_press) n_inv++;
            if (bus.valid_vote_casted && bus.invalid_press) excl_err++;
            if (bus.candidate1_button_press) saw_press1 = 1'b1;
        end
    end

    function automatic logic [15:0] tallies();
        return {bus.candidate4_vote, bus.candidate3_vote,
                bus.candidate2_vote, bus.candidate1_vote};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        if (k >= 100) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Press a pattern cleanly, hold, release, let everything settle.
    task automatic run_vec(input vec_t v);
        int v0, i0;
        wait_idle();
        bus.mode = v.mode;
        @(posedge clock); #1;
        v0 = n_valid;
        i0 = n_inv;
        bus.button_raw = v.press;
        repeat (10) @(posedge clock);
        #1;
        check({v.name, "_level"}, {28'd0, bus.candidate4_button_press, bus.candidate3_button_press,
              bus.candidate2_button_press, bus.candidate1_button_press}, {28'd0, v.exp_level});
        bus.button_raw = 4'b0000;
        repeat (25) @(posedge clock);
        #1;
        check({v.name, "_valid"}, 32'(n_valid - v0), 32'(v.exp_valid));
        check({v.name, "_invalid"}, 32'(n_inv - i0), 32'(v.exp_invalid));
        check({v.name, "_tally"}, {16'd0, tallies()}, {16'd0, v.exp_tally});
        check({v.name, "_busy"}, {31'd0, bus.busy}, 32'd0);
        bus.mode = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        int k;
        k = 0;
        while (!bus.valid_vote_casted && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        if (k >= 20) check({name, "_pulse_timeout"}, 32'd1, 32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        int first_edge, pulses, busy_cycles, v0;
        logic busy17;
        vec_t sv;

        vecs[0] = '{"simul_0101",  1'b0, 4'b0101, 0, 1, 4'b0101, 16'h0011};
        vecs[1] = '{"result_c4",   1'b1, 4'b1000, 0, 0, 4'b1000, 16'h0011};
        vecs[2] = '{"vote_c3",     1'b0, 4'b0100, 1, 0, 4'b0100, 16'h0111};
        vecs[3] = '{"simul_1111",  1'b0, 4'b1111, 0, 1, 4'b1111, 16'h0111};
        vecs[4] = '{"simul_0110",  1'b0, 4'b0110, 0, 1, 4'b0110, 16'h0111};
        vecs[5] = '{"result_0101", 1'b1, 4'b0101, 0, 0, 4'b0101, 16'h0111};
        vecs[6] = '{"vote_c2",     1'b0, 4'b0010, 1, 0, 4'b0010, 16'h0121};

        reset = 1'b1;
        bus.mode = 1'b0;
        bus.button_raw = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {25'd0, bus.valid_vote_casted, bus.invalid_press, bus.busy,
              bus.candidate4_button_press, bus.candidate3_button_press,
              bus.candidate2_button_press, bus.candidate1_button_press}, 32'd0);
        check("reset_tally", {16'd0, tallies()}, 32'd0);

        // Single vote: raw set just after edge 0, pulse expected at edge 7.
        @(posedge clock);
        reset = 1'b0;
        #1;
        bus.button_raw = 4'b0010;
        first_edge = 0; pulses = 0; busy_cycles = 0; busy17 = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock); #1;
            if (bus.valid_vote_casted) begin
                if (pulses == 0) first_edge = e;
                pulses++;
            end
            if (bus.busy) busy_cycles++;
            if (e == 17) busy17 = bus.busy;
        end
        check("single_pulses", 32'(pulses), 32'd1);
        check("single_pulse_edge", 32'(first_edge), 32'd7);
        check("single_busy_cycles", 32'(busy_cycles), 32'd10);
        check("single_busy_after", {31'd0, busy17}, 32'd0);
        check("single_tally", {16'd0, tallies()}, 32'h0010);
        bus.button_raw = 4'b0000;
        repeat (10) @(posedge clock);
        #1;

        // Bounce: bit0 high 2 cycles / low 2 cycles, never stable long enough.
        saw_press1 = 1'b0;
        v0 = n_valid;
        for (int p = 0; p < 5; p++) begin
            bus.button_raw = 4'b0001;
            repeat (2) @(posedge clock);
            #1;
            bus.button_raw = 4'b0000;
            repeat (2) @(posedge clock);
            #1;
        end
        repeat (15) @(posedge clock);
        #1;
        check("bounce_valid", 32'(n_valid - v0), 32'd0);
        check("bounce_tally", {16'd0, tallies()}, 32'h0010);
        check("bounce_level", {31'd0, saw_press1}, 32'd0);

        // Vote cand1, then a clean cand3 press that matures inside lockout.
        v0 = n_valid;
        bus.button_raw = 4'b0001;
        wait_pulse("lock_c1");
        bus.button_raw = 4'b0100;
        repeat (8) @(posedge clock);
        #1;
        bus.button_raw = 4'b0000;
        repeat (25) @(posedge clock);
        #1;
        check("lockout_valid", 32'(n_valid - v0), 32'd1);
        check("lockout_tally", {16'd0, tallies()}, 32'h0011);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Saturation: 16 separate cand4 votes, tally stops at 15.
        v0 = n_valid;
        for (int i = 0; i < 16; i++) begin
            sv = '{"sat_c4", 1'b0, 4'b1000, 1, 0, 4'b1000,
                   {((i + 1) > 15) ? 4'hF : 4'(i + 1), 12'h121}};
            run_vec(sv);
        end
        check("sat_pulses", 32'(n_valid - v0), 32'd16);
        check("sat_tally4", {28'd0, bus.candidate4_vote}, 32'd15);

        // Reset at lockout count 5.
        bus.button_raw = 4'b0001;
        wait_pulse("rst_c1");
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        bus.button_raw = 4'b0000;
        @(posedge clock); #1;
        check("rst_tally", {16'd0, tallies()}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_vote_casted}, 32'd0);
        reset = 1'b0;
        sv = '{"post_rst_c1", 1'b0, 4'b0001, 1, 0, 4'b0001, 16'h0001};
        run_vec(sv);

        check("valid_invalid_exclusive", 32'(excl_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
